// File: rtl/jtgng_sdram_arb_pkg.sv
// rtl/jtgng_sdram_arb_pkg.sv - shared encodings and widths for the SDRAM read arbiter
package jtgng_sdram_arb_pkg;

  // Default SDRAM word address width and cached data width
  localparam int AW_DEF = 22;
  localparam int DW     = 32;

  // Arbiter FSM: scan for a miss, hold the request, wait for the data beat
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/jtgng_sdram_arb_if.sv
// rtl/jtgng_sdram_arb_if.sv - slot-side and controller-side bus of the SDRAM read arbiter
interface jtgng_sdram_arb_if
  import jtgng_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = AW_DEF
);

  // ROM consumer side
  logic                  downloading;
  logic [SLOTS-1:0]      slot_cs;
  logic [SLOTS*AW-1:0]   slot_addr;
  logic [SLOTS-1:0]      slot_ok;
  logic [SLOTS*DW-1:0]   slot_dout;

  // SDRAM controller side
  logic                  read_req;
  logic [AW-1:0]         sdram_addr;
  logic                  sdram_ack;
  logic                  data_rdy;
  logic [DW-1:0]         data_read;
  logic                  refresh_en;

  // The arbiter itself
  modport master (
    input  downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    output slot_ok, slot_dout, read_req, sdram_addr, refresh_en
  );

  // Consumers plus controller, seen from outside the arbiter
  modport slave (
    output downloading, slot_cs, slot_addr, sdram_ack, data_rdy, data_read,
    input  slot_ok, slot_dout, read_req, sdram_addr, refresh_en
  );

endinterface

// File: rtl/jtgng_sdram_slot.sv
// rtl/jtgng_sdram_slot.sv - one-word read cache for a single ROM consumer
module jtgng_sdram_slot
  import jtgng_sdram_arb_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          inval,
  input  logic          fill,
  input  logic [AW-1:0] fill_addr,
  input  logic [DW-1:0] fill_data,
  output logic          ok,
  output logic          miss,
  output logic [DW-1:0] dout
);

  logic          valid_q, valid_d;
  logic [AW-1:0] cached_addr_q, cached_addr_d;
  logic [DW-1:0] cached_data_q, cached_data_d;
  logic          hit;

  // Fill stores the issued address, so a consumer that moved on during the
  // fetch simply misses again. Invalidate wins over fill for the valid bit so
  // a fetch finishing during a ROM download never leaves a stale hit behind.
  always_comb begin
    valid_d       = valid_q;
    cached_addr_d = cached_addr_q;
    cached_data_d = cached_data_q;
    if (fill) begin
      valid_d       = 1'b1;
      cached_addr_d = fill_addr;
      cached_data_d = fill_data;
    end
    if (inval) begin
      valid_d = 1'b0;
    end
  end

  // Cache registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= 1'b0;
      cached_addr_q <= '0;
      cached_data_q <= '0;
    end else begin
      valid_q       <= valid_d;
      cached_addr_q <= cached_addr_d;
      cached_data_q <= cached_data_d;
    end
  end

  assign hit  = cs & valid_q & (addr == cached_addr_q);
  assign ok   = hit;
  assign miss = cs & ~hit;
  assign dout = cached_data_q;

endmodule

// File: rtl/jtgng_sdram_arb.sv
// rtl/jtgng_sdram_arb.sv - round-robin read arbiter between ROM slots and the SDRAM controller
module jtgng_sdram_arb
  import jtgng_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = AW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  jtgng_sdram_arb_if.master bus
);

  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  arb_state_e          state_q, state_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [AW-1:0]       gnt_addr_q, gnt_addr_d;
  logic                read_req_q, read_req_d;

  logic [SLOTS-1:0]    miss;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*DW-1:0] slot_dout;
  logic                any_miss;
  logic                fill_en;

  logic                found_lo, found_hi;
  logic [IW-1:0]       idx_lo, idx_hi;
  logic                pick_found;
  logic [IW-1:0]       pick_idx;
  logic [AW-1:0]       pick_addr;

  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    jtgng_sdram_slot #(.AW(AW)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .cs        (bus.slot_cs[i]),
      .addr      (bus.slot_addr[i*AW +: AW]),
      .inval     (bus.downloading),
      .fill      (fill_en && (last_grant_q == IW'(i))),
      .fill_addr (gnt_addr_q),
      .fill_data (bus.data_read),
      .ok        (slot_ok[i]),
      .miss      (miss[i]),
      .dout      (slot_dout[i*DW +: DW])
    );
  end

  assign any_miss = |miss;

  // Round-robin pick: the lowest missing slot above the last grant, else wrap
  // around to the lowest missing slot overall.
  always_comb begin
    found_lo  = 1'b0;
    found_hi  = 1'b0;
    idx_lo    = '0;
    idx_hi    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (miss[i] && !found_lo) begin
        found_lo = 1'b1;
        idx_lo   = IW'(i);
      end
      if (miss[i] && !found_hi && (IW'(i) > last_grant_q)) begin
        found_hi = 1'b1;
        idx_hi   = IW'(i);
      end
    end
    pick_found = found_lo;
    pick_idx   = found_hi ? idx_hi : idx_lo;
    pick_addr  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (pick_idx == IW'(i)) begin
        pick_addr = bus.slot_addr[i*AW +: AW];
      end
    end
  end

  // FSM next state and controller-side register updates
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_addr_d   = gnt_addr_q;
    read_req_d   = read_req_q;
    fill_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!bus.downloading && pick_found) begin
          last_grant_d = pick_idx;
          gnt_addr_d   = pick_addr;
          read_req_d   = 1'b1;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus.sdram_ack) begin
          read_req_d = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.data_rdy) begin
          fill_en = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        read_req_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // State and controller-side registers; slot 0 is scanned first after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= IW'(SLOTS - 1);
      gnt_addr_q   <= '0;
      read_req_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_addr_q   <= gnt_addr_d;
      read_req_q   <= read_req_d;
    end
  end

  assign bus.slot_ok    = slot_ok;
  assign bus.slot_dout  = slot_dout;
  assign bus.read_req   = read_req_q;
  assign bus.sdram_addr = gnt_addr_q;
  // Refresh only when nobody is waiting on the SDRAM and never during reset
  assign bus.refresh_en = ~rst & (state_q == ST_IDLE) & ~any_miss & ~bus.downloading;

endmodule

// File: tb/tb_jtgng_sdram_arb.sv
// tb/tb_jtgng_sdram_arb.sv - self-checking bench for the SDRAM read arbiter
module tb_jtgng_sdram_arb;
  import jtgng_sdram_arb_pkg::*;

  localparam int SLOTS = 4;
  localparam int AW    = 22;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jtgng_sdram_arb_if #(.SLOTS(SLOTS), .AW(AW)) bus ();

  jtgng_sdram_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Controller model: accepts read_req when idle, ack 1 cycle after accept,
  // data 4 cycles after accept.
  logic          ctl_busy, ctl_ack, ctl_rdy;
  int            ctl_cnt;
  logic [31:0]   ctl_data;
  logic [AW-1:0] ctl_addr;
  logic          man_rdy;
  logic [31:0]   man_data;
  logic [AW-1:0] issued[$];

  assign bus.sdram_ack = ctl_ack;
  assign bus.data_rdy  = ctl_rdy | man_rdy;
  assign bus.data_read = man_rdy ? man_data : ctl_data;

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    if (a == 22'h00123) return 32'hDEADBEEF;
    return (32'(a) * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_busy <= 1'b0;
      ctl_cnt  <= 0;
      ctl_ack  <= 1'b0;
      ctl_rdy  <= 1'b0;
      ctl_data <= '0;
      ctl_addr <= '0;
    end else if (!ctl_busy) begin
      ctl_ack <= 1'b0;
      ctl_rdy <= 1'b0;
      if (bus.read_req) begin
        ctl_busy <= 1'b1;
        ctl_cnt  <= 1;
        ctl_ack  <= 1'b1;
        ctl_addr <= bus.sdram_addr;
        issued.push_back(bus.sdram_addr);
      end
    end else begin
      ctl_cnt <= ctl_cnt + 1;
      ctl_ack <= 1'b0;
      if (ctl_cnt == 3) begin
        ctl_rdy  <= 1'b1;
        ctl_data <= mem_word(ctl_addr);
      end
      if (ctl_cnt == 4) begin
        ctl_rdy  <= 1'b0;
        ctl_busy <= 1'b0;
      end
    end
  end

  // Reference cache model
  logic          m_valid[SLOTS];
  logic [AW-1:0] m_addr[SLOTS];
  int            m_last;
  logic          req_cs[SLOTS];
  logic [AW-1:0] req_addr[SLOTS];
  int            last_lat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic cs, input logic [AW-1:0] a);
    bus.slot_cs[i]             = cs;
    bus.slot_addr[i*AW +: AW]  = a;
  endtask

  task automatic m_reset();
    for (int i = 0; i < SLOTS; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
    end
    m_last = SLOTS - 1;
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.slot_cs     = '0;
    bus.slot_addr   = '0;
    bus.downloading = 1'b0;
    man_rdy         = 1'b0;
    man_data        = '0;
    step();
    step();
    rst = 1'b0;
    #1;
    m_reset();
  endtask

  task automatic wait_idle(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (bus.refresh_en !== 1'b1 && cycles < budget) begin
      step();
      cycles++;
    end
    chk({tag, "_idle"}, 64'(bus.refresh_en), 64'd1);
  endtask

  task automatic wait_sig_ack(input string tag);
    int n;
    n = 0;
    while (bus.sdram_ack !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_ack_seen"}, 64'(bus.sdram_ack), 64'd1);
  endtask

  // Apply req_cs/req_addr to all slots, predict the fetch sequence from the
  // cache model and round-robin rule, and check the settled result.
  task automatic run_round(input string tag);
    int   start;
    int   exp_q[$];
    logic pend[SLOTS];
    logic any_pend;
    int   p;
    int   lat;
    start    = issued.size();
    any_pend = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      pend[i]  = req_cs[i] && !(m_valid[i] && (m_addr[i] == req_addr[i]));
      any_pend = any_pend | pend[i];
      set_slot(i, req_cs[i], req_addr[i]);
    end
    #1;
    chk({tag, "_refresh_gate"}, 64'(bus.refresh_en), 64'(!any_pend));
    p = m_last;
    for (int k = 0; k < SLOTS; k++) begin
      p = (p + 1) % SLOTS;
      if (pend[p]) exp_q.push_back(p);
    end
    wait_idle(tag, 40 * SLOTS, lat);
    last_lat = lat;
    chk({tag, "_n_fetch"}, 64'(issued.size() - start), 64'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++) begin
      if (start + j < issued.size()) begin
        chk($sformatf("%s_fetch%0d_addr", tag, j), 64'(issued[start+j]), 64'(req_addr[exp_q[j]]));
      end
    end
    foreach (exp_q[j]) begin
      m_valid[exp_q[j]] = 1'b1;
      m_addr[exp_q[j]]  = req_addr[exp_q[j]];
      m_last            = exp_q[j];
    end
    for (int i = 0; i < SLOTS; i++) begin
      if (req_cs[i]) begin
        chk($sformatf("%s_ok%0d", tag, i), 64'(bus.slot_ok[i]), 64'd1);
        chk($sformatf("%s_dout%0d", tag, i), 64'(bus.slot_dout[i*32 +: 32]), 64'(mem_word(req_addr[i])));
      end else begin
        chk($sformatf("%s_ok%0d_idle", tag, i), 64'(bus.slot_ok[i]), 64'd0);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base;
    int lat;
    logic [AW-1:0] dl_addr;

    // Reset state
    rst             = 1'b1;
    bus.slot_cs     = '0;
    bus.slot_addr   = '0;
    bus.downloading = 1'b0;
    man_rdy         = 1'b0;
    man_data        = '0;
    step();
    chk("rst_read_req", 64'(bus.read_req), 64'd0);
    chk("rst_sdram_addr", 64'(bus.sdram_addr), 64'd0);
    chk("rst_refresh_en", 64'(bus.refresh_en), 64'd0);
    chk("rst_slot_dout", 64'(bus.slot_dout[63:0]), 64'd0);
    bus.slot_cs = '1;
    #1;
    chk("rst_slot_ok_addr0", 64'(bus.slot_ok), 64'd0);
    bus.slot_cs = '0;
    do_reset();
    chk("post_rst_refresh_en", 64'(bus.refresh_en), 64'd1);

    // Single miss on slot 1
    base = issued.size();
    for (int i = 0; i < SLOTS; i++) begin
      req_cs[i]   = 1'b0;
      req_addr[i] = '0;
    end
    req_cs[1]   = 1'b1;
    req_addr[1] = 22'h00123;
    run_round("single");
    chk("single_latency", 64'(last_lat >= 5 && last_lat <= 8), 64'd1);
    chk("single_dout_const", 64'(bus.slot_dout[32 +: 32]), 64'hDEADBEEF);
    repeat (10) step();
    chk("single_no_more_req", 64'(bus.read_req), 64'd0);
    chk("single_one_access", 64'(issued.size() - base), 64'd1);

    // Round robin: all slots miss after reset, then slots 0 and 2 again
    do_reset();
    for (int i = 0; i < SLOTS; i++) begin
      req_cs[i]   = 1'b1;
      req_addr[i] = AW'((i << 12) | 'h40);
    end
    base = issued.size();
    run_round("rr_all");
    chk("rr_all_first_slot0", 64'(issued[base]), 64'(22'h00040));
    req_addr[0] = 22'h00041;
    req_addr[2] = 22'h02041;
    base = issued.size();
    run_round("rr_02");
    chk("rr_02_first_slot0", 64'(issued[base]), 64'(22'h00041));

    // Address change while the fetch is in WAIT
    for (int i = 0; i < SLOTS; i++) set_slot(i, 1'b0, req_addr[i]);
    base = issued.size();
    set_slot(2, 1'b1, 22'h00010);
    wait_sig_ack("chg");
    step();
    set_slot(2, 1'b1, 22'h00011);
    #1;
    chk("chg_ok_in_wait", 64'(bus.slot_ok[2]), 64'd0);
    lat = 0;
    while (bus.data_rdy !== 1'b1 && lat < 30) begin
      step();
      lat++;
    end
    chk("chg_data_rdy_seen", 64'(bus.data_rdy), 64'd1);
    step();
    set_slot(2, 1'b1, 22'h00010);
    #1;
    chk("chg_cache_holds_old_ok", 64'(bus.slot_ok[2]), 64'd1);
    chk("chg_cache_holds_old_dout", 64'(bus.slot_dout[64 +: 32]), 64'(mem_word(22'h00010)));
    set_slot(2, 1'b1, 22'h00011);
    #1;
    chk("chg_new_addr_miss", 64'(bus.slot_ok[2]), 64'd0);
    wait_idle("chg", 100, lat);
    chk("chg_n_fetch", 64'(issued.size() - base), 64'd2);
    chk("chg_fetch0", 64'(issued[base]), 64'(22'h00010));
    chk("chg_fetch1", 64'(issued[base+1]), 64'(22'h00011));
    chk("chg_final_ok", 64'(bus.slot_ok[2]), 64'd1);
    chk("chg_final_dout", 64'(bus.slot_dout[64 +: 32]), 64'(mem_word(22'h00011)));
    m_valid[2] = 1'b1;
    m_addr[2]  = 22'h00011;
    m_last     = 2;

    // Download with slot 0 cached
    dl_addr = 22'h00500;
    for (int i = 0; i < SLOTS; i++) req_cs[i] = 1'b0;
    req_cs[0]   = 1'b1;
    req_addr[0] = dl_addr;
    run_round("dl_prep");
    base = issued.size();
    bus.downloading = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      chk($sformatf("dl_ok0_c%0d", c), 64'(bus.slot_ok[0]), 64'd0);
      chk($sformatf("dl_req_c%0d", c), 64'(bus.read_req), 64'd0);
    end
    chk("dl_refresh_off", 64'(bus.refresh_en), 64'd0);
    bus.downloading = 1'b0;
    #1;
    chk("dl_after_ok0", 64'(bus.slot_ok[0]), 64'd0);
    wait_idle("dl_refetch", 100, lat);
    chk("dl_n_fetch", 64'(issued.size() - base), 64'd1);
    chk("dl_fetch_addr", 64'(issued[base]), 64'(dl_addr));
    chk("dl_final_ok0", 64'(bus.slot_ok[0]), 64'd1);

    // Reset while in WAIT, then a stray data_rdy
    do_reset();
    set_slot(1, 1'b1, 22'h00777);
    wait_sig_ack("rstw");
    step();
    rst = 1'b1;
    bus.slot_cs = '0;
    #1;
    chk("rstw_read_req", 64'(bus.read_req), 64'd0);
    chk("rstw_slot_ok", 64'(bus.slot_ok), 64'd0);
    chk("rstw_refresh_en", 64'(bus.refresh_en), 64'd0);
    step();
    rst = 1'b0;
    #1;
    man_data = 32'hCAFEF00D;
    man_rdy  = 1'b1;
    step();
    man_rdy  = 1'b0;
    chk("rstw_stray_no_req", 64'(bus.read_req), 64'd0);
    for (int i = 0; i < SLOTS; i++) set_slot(i, 1'b1, '0);
    set_slot(1, 1'b1, 22'h00777);
    #1;
    chk("rstw_all_invalid", 64'(bus.slot_ok), 64'd0);

    // Randomized rounds against the reference model
    do_reset();
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < SLOTS; i++) begin
        req_cs[i]   = ($urandom_range(0, 3) != 0);
        req_addr[i] = AW'((i << 8) | $urandom_range(0, 2));
      end
      run_round($sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
